// File: rtl/conv_output_collector.sv
`timescale 1ns/1ps
// Convolver result collector: bias, rounding requantise, optional ReLU and saturation,
// tagged with output row/column and buffered in a first-word-fall-through FIFO.
module conv_output_collector #(
    parameter int Bits          = 16,
    parameter int MaxMatrixSize = 28,
    parameter int FifoDepth     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [13:0]       out_size_i,
    input  logic [5:0]        shift_i,
    input  logic [2*Bits-1:0] bias_i,
    input  logic              relu_en_i,
    input  logic [2*Bits-1:0] conv_i,
    input  logic              valid_conv_i,
    input  logic              conv_en_i,
    input  logic              end_conv_i,
    output logic              stall_o,
    output logic [Bits-1:0]   data_o,
    output logic [13:0]       row_o,
    output logic [13:0]       col_o,
    output logic              last_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              done_o,
    output logic              overflow_o,
    output logic              count_error_o,
    output logic [1:0]        state_o
);
    localparam int CW = 2 * Bits;
    localparam int EW = CW + 2;
    localparam int AW = $clog2(FifoDepth);
    localparam int DW = Bits + 14 + 14 + 1;
    localparam logic [13:0]          MAX_SIZE    = 14'(MaxMatrixSize);
    localparam logic [AW:0]          DEPTH       = (AW + 1)'(FifoDepth);
    localparam logic [AW+1:0]        STALL_LEVEL = (AW + 2)'(FifoDepth - 2);
    localparam logic signed [EW-1:0] SAT_MAX     = {{(EW - Bits + 1){1'b0}}, {(Bits - 1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN     = {{(EW - Bits + 1){1'b1}}, {(Bits - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [13:0]          r_out_size, r_row, r_col, w_size_in;
    logic [5:0]           r_shift;
    logic [CW-1:0]        r_bias;
    logic                 r_relu;
    logic [27:0]          r_count, w_count_next, w_total;
    logic                 w_accept, w_col_wrap, w_last;

    logic                 r_s1_valid, r_s1_last;
    logic signed [CW:0]   r_s1_sum;
    logic [13:0]          r_s1_row, r_s1_col;
    logic                 r_s2_valid, r_s2_last;
    logic [Bits-1:0]      r_s2_data, w_sat;
    logic [13:0]          r_s2_row, r_s2_col;
    logic signed [EW-1:0] w_ext, w_half, w_shifted, w_relu;

    logic [DW-1:0]        r_mem [FifoDepth];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_occ;
    logic [AW+1:0]        w_level;
    logic [DW-1:0]        w_head;
    logic                 w_full, w_pop, w_push_ok, w_drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = S_RUN;
            S_RUN:   if (end_conv_i) w_state_next = S_DRAIN;
            S_DRAIN: if (!r_s1_valid && !r_s2_valid && r_occ == '0) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A zero or oversized request is clamped so the coordinate wrap stays well defined.
    assign w_size_in    = (out_size_i == 14'd0) ? 14'd1 :
                          (out_size_i > MAX_SIZE) ? MAX_SIZE : out_size_i;
    assign w_accept     = (r_state == S_RUN) && valid_conv_i && conv_en_i;
    assign w_col_wrap   = (r_col == r_out_size - 14'd1);
    assign w_last       = w_col_wrap && (r_row == r_out_size - 14'd1);
    assign w_count_next = (w_accept && r_count != '1) ? r_count + 28'd1 : r_count;
    assign w_total      = 28'(r_out_size) * 28'(r_out_size);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_size    <= '0;
            r_shift       <= '0;
            r_bias        <= '0;
            r_relu        <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_count       <= '0;
            overflow_o    <= 1'b0;
            count_error_o <= 1'b0;
        end else if (r_state == S_IDLE && start_i) begin
            r_out_size    <= w_size_in;
            r_shift       <= shift_i;
            r_bias        <= bias_i;
            r_relu        <= relu_en_i;
            r_row         <= '0;
            r_col         <= '0;
            r_count       <= '0;
            overflow_o    <= 1'b0;
            count_error_o <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col   <= w_col_wrap ? 14'd0 : r_col + 14'd1;
                r_row   <= w_col_wrap ? r_row + 14'd1 : r_row;
                r_count <= w_count_next;
            end
            if (r_state == S_RUN && end_conv_i) count_error_o <= (w_count_next != w_total);
            if (w_drop) overflow_o <= 1'b1;
        end
    end

    // Round half up: add half an LSB of the result before the arithmetic shift.
    always_comb begin
        w_ext     = {r_s1_sum[CW], r_s1_sum};
        w_half    = EW'(1) << (r_shift - 6'd1);
        w_shifted = (r_shift == 6'd0) ? w_ext : ((w_ext + w_half) >>> r_shift);
        w_relu    = (r_relu && w_shifted[EW-1]) ? SAT_MAX ^ SAT_MAX : w_shifted;
        if (w_relu > SAT_MAX)      w_sat = SAT_MAX[Bits-1:0];
        else if (w_relu < SAT_MIN) w_sat = SAT_MIN[Bits-1:0];
        else                       w_sat = w_relu[Bits-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_row   <= '0;
            r_s1_col   <= '0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_row   <= '0;
            r_s2_col   <= '0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_sum   <= {conv_i[CW-1], conv_i} + {r_bias[CW-1], r_bias};
            r_s1_row   <= r_row;
            r_s1_col   <= r_col;
            r_s1_last  <= w_last;
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_sat;
            r_s2_row   <= r_s1_row;
            r_s2_col   <= r_s1_col;
            r_s2_last  <= r_s1_last;
        end
    end

    // Stream handshake: a word transfers on every edge where valid_o && ready_i.
    assign w_full    = (r_occ == DEPTH);
    assign w_pop     = valid_o && ready_i;
    assign w_push_ok = r_s2_valid && (!w_full || w_pop);
    assign w_drop    = r_s2_valid && w_full && !w_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_occ <= r_occ + 1'b1;
            else if (!w_push_ok && w_pop) r_occ <= r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {r_s2_data, r_s2_row, r_s2_col, r_s2_last};
    end

    always_comb begin
        w_head  = r_mem[r_rd_ptr];
        valid_o = (r_occ != '0);
        {data_o, row_o, col_o, last_o} = valid_o ? w_head : '0;
        w_level = (AW + 2)'(r_occ) + (AW + 2)'(r_s1_valid) + (AW + 2)'(r_s2_valid);
        stall_o = (w_level >= STALL_LEVEL);
        done_o  = (r_state == S_DONE);
        state_o = r_state;
    end
endmodule

// File: tb/tb_conv_output_collector.sv
`timescale 1ns/1ps
// Bench for conv_output_collector: queue-based reference model, per-cycle compare,
// directed literal checks and randomised collection runs.
module tb_conv_output_collector;
    localparam int Depth = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i, relu_en_i, valid_conv_i, conv_en_i, end_conv_i, ready_i;
    logic [13:0] out_size_i;
    logic [5:0]  shift_i;
    logic [31:0] bias_i, conv_i;
    logic        stall_o, last_o, valid_o, done_o, overflow_o, count_error_o;
    logic [15:0] data_o;
    logic [13:0] row_o, col_o;
    logic [1:0]  state_o;

    conv_output_collector #(.Bits(16), .MaxMatrixSize(28), .FifoDepth(Depth)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .out_size_i(out_size_i),
        .shift_i(shift_i), .bias_i(bias_i), .relu_en_i(relu_en_i), .conv_i(conv_i),
        .valid_conv_i(valid_conv_i), .conv_en_i(conv_en_i), .end_conv_i(end_conv_i),
        .stall_o(stall_o), .data_o(data_o), .row_o(row_o), .col_o(col_o), .last_o(last_o),
        .valid_o(valid_o), .ready_i(ready_i), .done_o(done_o), .overflow_o(overflow_o),
        .count_error_o(count_error_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { longint data; longint row; longint col; bit last; } item_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint requant(longint conv, longint bias, int sh, bit relu);
        longint s, r;
        s = conv + bias;
        if (sh == 0) r = s;
        else         r = (s + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference model: phase, latched config, two in-flight slots and a bounded queue.
    int     m_state, m_n, m_shift, m_k;
    longint m_bias;
    bit     m_relu, m_ovf, m_cerr, s1v, s2v, m_pop, m_drained, m_acc;
    item_t  s1, s2;
    item_t  m_fifo[$];

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_state = 0; m_k = 0; m_ovf = 0; m_cerr = 0; s1v = 0; s2v = 0;
            m_fifo.delete();
        end else begin
            m_pop     = (m_fifo.size() > 0) && ready_i;
            m_drained = !s1v && !s2v && (m_fifo.size() == 0);
            m_acc     = (m_state == 1) && valid_conv_i && conv_en_i;
            if (m_pop) void'(m_fifo.pop_front());
            if (s2v) begin
                if (m_fifo.size() >= Depth) m_ovf = 1;
                else                        m_fifo.push_back(s2);
            end
            s2v = s1v; s2 = s1; s1v = m_acc;
            if (m_acc) begin
                s1.data = requant(longint'($signed(conv_i)), m_bias, m_shift, m_relu);
                s1.row  = (m_k / m_n) % 16384;
                s1.col  = m_k % m_n;
                s1.last = (m_k == m_n * m_n - 1);
                m_k++;
            end
            case (m_state)
                0: if (start_i) begin
                    m_state = 1; m_n = int'(out_size_i); m_shift = int'(shift_i);
                    m_bias = longint'($signed(bias_i)); m_relu = relu_en_i;
                    m_k = 0; m_ovf = 0; m_cerr = 0;
                end
                1: if (end_conv_i) begin m_state = 2; m_cerr = (m_k != m_n * m_n); end
                2: if (m_drained) m_state = 3;
                default: m_state = 0;
            endcase
        end
    end

    item_t pop_log[$];

    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("valid_o", valid_o, m_fifo.size() > 0);
            if (valid_o && m_fifo.size() > 0) begin
                chk("data_o", $signed(data_o), m_fifo[0].data);
                chk("row_o", row_o, m_fifo[0].row);
                chk("col_o", col_o, m_fifo[0].col);
                chk("last_o", last_o, m_fifo[0].last);
            end
            chk("stall_o", stall_o, (m_fifo.size() + s1v + s2v) >= Depth - 2);
            chk("overflow_o", overflow_o, m_ovf);
            chk("count_error_o", count_error_o, m_cerr);
            chk("done_o", done_o, m_state == 3);
            chk("state_o", state_o, m_state);
            if (valid_o && ready_i)
                pop_log.push_back('{longint'($signed(data_o)), longint'(row_o), longint'(col_o), last_o});
        end
    end

    task automatic drive(input bit v, input bit e, input logic [31:0] c, input bit endc, input bit rdy);
        @(posedge clk_i); #2;
        valid_conv_i = v; conv_en_i = e; conv_i = c; end_conv_i = endc; ready_i = rdy;
    endtask

    task automatic start_run(input int n, input int sh, input logic [31:0] b, input bit relu);
        @(posedge clk_i); #2;
        start_i = 1; out_size_i = 14'(n); shift_i = 6'(sh); bias_i = b; relu_en_i = relu;
        valid_conv_i = 0; conv_en_i = 0; end_conv_i = 0;
        @(posedge clk_i); #2;
        start_i = 0;
    endtask

    task automatic drain(input string name);
        bit seen;
        seen = 0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            drive(0, 0, 32'd0, 0, 1);
            @(negedge clk_i);
            if (done_o) seen = 1;
        end
        chk(name, seen, 1);
        drive(0, 0, 32'd0, 0, 1);
        drive(0, 0, 32'd0, 0, 1);
    endtask

    task automatic rand_run();
        int n, target, acc;
        bit v, e, endnow, ended;
        logic [31:0] c;
        n = $urandom_range(1, 5);
        target = n * n;
        case ($urandom_range(0, 3))
            0: target = target - 1;
            1: target = target + 1;
            default: ;
        endcase
        start_run(n, $urandom_range(0, 31), 32'($signed($urandom) >>> $urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
        acc = 0; ended = 0;
        for (int cyc = 0; cyc < 500 && acc < target && !ended; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 4) != 0);
            c = 32'($signed($urandom) >>> $urandom_range(0, 24));
            endnow = v && e && (acc + 1 == target) && ($urandom_range(0, 1) == 1);
            drive(v, e, c, endnow, $urandom_range(0, 3) != 0);
            if (v && e) acc++;
            ended = endnow;
        end
        if (!ended) drive(0, 0, 32'd0, 1, $urandom_range(0, 1) == 1);
        drain("rand_done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        start_i = 0; relu_en_i = 0; valid_conv_i = 0; conv_en_i = 0; end_conv_i = 0;
        ready_i = 0; out_size_i = 0; shift_i = 0; bias_i = 0; conv_i = 0;

        chk("model_round", requant(296, 0, 4, 0), 19);
        chk("model_sat_hi", requant(64'sh100000, 0, 0, 0), 32767);
        chk("model_relu", requant(-64'sh100000, 0, 0, 1), 0);

        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1;
        @(negedge clk_i);
        chk("rst_valid", valid_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_cerr", count_error_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_data", data_o, 0);

        // Single result and its two-edge latency.
        start_run(1, 4, 32'd0, 0);
        drive(1, 1, 32'd296, 0, 0);
        drive(0, 0, 32'd0, 0, 0);
        @(negedge clk_i) chk("t1_lat_n", valid_o, 0);
        drive(0, 0, 32'd0, 0, 0);
        @(negedge clk_i) chk("t1_lat_n1", valid_o, 0);
        drive(0, 0, 32'd0, 0, 0);
        @(negedge clk_i);
        chk("t1_valid", valid_o, 1);
        chk("t1_data", $signed(data_o), 19);
        chk("t1_row", row_o, 0);
        chk("t1_col", col_o, 0);
        chk("t1_last", last_o, 1);
        drive(0, 0, 32'd0, 1, 0);
        drain("t1_done");
        chk("t1_cerr", count_error_o, 0);

        // Saturation, ReLU and negative bias.
        base = pop_log.size();
        start_run(2, 0, 32'd0, 0);
        drive(1, 1, 32'h0010_0000, 0, 1);
        drive(1, 1, 32'hFFF0_0000, 1, 1);
        drain("t2_done");
        chk("t2_cnt", pop_log.size(), base + 2);
        chk("t2_sat_hi", pop_log[base].data, 32767);
        chk("t2_sat_lo", pop_log[base + 1].data, -32768);
        base = pop_log.size();
        start_run(1, 0, 32'd0, 1);
        drive(1, 1, 32'hFFF0_0000, 1, 1);
        drain("t2r_done");
        chk("t2_relu", pop_log[base].data, 0);
        base = pop_log.size();
        start_run(1, 0, -32'sd5, 0);
        drive(1, 1, 32'd3, 1, 1);
        drain("t2b_done");
        chk("t2_bias", pop_log[base].data, -2);

        // Raster order for a 3x3 output.
        base = pop_log.size();
        start_run(3, $urandom_range(0, 8), 32'($urandom_range(0, 200)), 0);
        for (int k = 0; k < 9; k++) drive(1, 1, 32'($urandom_range(0, 65535)), k == 8, 1);
        drain("t3_done");
        chk("t3_cnt", pop_log.size(), base + 9);
        chk("t3_row3", pop_log[base + 3].row, 1);
        chk("t3_col3", pop_log[base + 3].col, 0);
        chk("t3_last7", pop_log[base + 7].last, 0);
        chk("t3_last8", pop_log[base + 8].last, 1);
        chk("t3_cerr", count_error_o, 0);

        // Backpressure: stall threshold and overflow on the ninth word.
        base = pop_log.size();
        start_run(3, 2, 32'd0, 0);
        for (int k = 1; k <= 9; k++) begin
            drive(1, 1, 32'($urandom_range(0, 4095)), k == 9, 0);
            @(negedge clk_i);
            if (k == 6) chk("t4_stall5", stall_o, 0);
            if (k == 7) chk("t4_stall6", stall_o, 1);
        end
        repeat (3) drive(0, 0, 32'd0, 0, 0);
        @(negedge clk_i);
        chk("t4_ovf", overflow_o, 1);
        drain("t4_done");
        chk("t4_cnt", pop_log.size(), base + 8);
        chk("t4_row7", pop_log[base + 7].row, 2);
        chk("t4_col7", pop_log[base + 7].col, 1);

        // Held convolver output is filtered; short count flags an error.
        base = pop_log.size();
        start_run(3, 1, 32'd7, 0);
        drive(1, 0, 32'd1234, 0, 1);
        for (int k = 0; k < 8; k++) drive(1, 1, 32'($urandom_range(0, 9999)), 0, 1);
        drive(0, 0, 32'd0, 1, 1);
        drain("t5_done");
        chk("t5_cerr", count_error_o, 1);
        chk("t5_cnt", pop_log.size(), base + 8);
        chk("t5_col0", pop_log[base].col, 0);

        // Reset in the middle of a run.
        start_run(2, 0, 32'd0, 0);
        for (int k = 0; k < 4; k++) drive(1, 1, 32'(k + 1), 0, 0);
        repeat (3) drive(0, 0, 32'd0, 0, 0);
        @(negedge clk_i) chk("t6_pre_valid", valid_o, 1);
        @(posedge clk_i); #2 rst_ni = 0;
        #1;
        chk("t6_valid", valid_o, 0);
        chk("t6_stall", stall_o, 0);
        chk("t6_state", state_o, 0);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1;
        base = pop_log.size();
        start_run(2, 0, 32'd0, 0);
        for (int k = 0; k < 4; k++) drive(1, 1, 32'(k + 10), k == 3, 1);
        drain("t6_done");
        chk("t6_cnt", pop_log.size(), base + 4);
        chk("t6_row0", pop_log[base].row, 0);
        chk("t6_col0", pop_log[base].col, 0);
        chk("t6_data0", pop_log[base].data, 10);

        repeat (12) rand_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
